vedic_mul_pipe: RTL and testbench
=================================

VEDIC_MUL_PIPE -- requirements
Module: vedic_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; power of 2, >=4; other values SHALL trigger $fatal at elaboration.
REQ-002 SHALL have parameter MIN_MUL_LEVEL, default 4: log2 of the leaf sub-multiplier width forwarded to the unsigned vedic core.
REQ-003 SHALL have parameter TAG_WIDTH, default 4: width of the sideband tag.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  synchronous pipeline kill.
REQ-008 in_valid  input  1  operand beat valid.
REQ-009 in_ready  output  1  block accepts beat this cycle.
REQ-010 A  input  WIDTH  multiplicand.
REQ-011 B  input  WIDTH  multiplier.
REQ-012 mode  input  2  00 UU, 01 SS, 10 SU (A signed, B unsigned), 11 treated as UU.
REQ-013 in_tag  input  TAG_WIDTH  sideband carried with the beat.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  consumer accepts result.
REQ-016 Z  output  2*WIDTH  full product.
REQ-017 out_tag  output  TAG_WIDTH  tag of the beat in Z.
REQ-018 busy  output  1  any stage holds a valid beat.

Function
REQ-019 SHALL be a 3-stage pipeline: S1 registers operand magnitudes and result sign; S2 registers the four WIDTH/2 x WIDTH/2 partial products (la_lb, la_hb, ha_lb, ha_hb); S3 registers the recombined and sign-corrected 2*WIDTH product.
REQ-020 Latency SHALL be exactly 3 cycles from accept (in_valid&in_ready) to out_valid when out_ready stays high.
REQ-021 Throughput SHALL be one beat per cycle when out_ready stays high.
REQ-022 Stage k SHALL load when it is empty or stage k+1 loads in the same cycle; S3 frees when out_ready=1; bubbles SHALL collapse.
REQ-023 in_ready SHALL equal (!s1_valid | s1 advancing) & !flush, combinationally.
REQ-024 While out_valid=1 and out_ready=0, Z and out_tag SHALL hold stable.
REQ-025 Signed operands SHALL be converted to WIDTH-bit unsigned magnitudes; the most negative value maps to 2^(WIDTH-1) without overflow.
REQ-026 Result sign SHALL be A[MSB]^B[MSB] for SS, A[MSB] for SU, 0 for UU and mode 11; a negative result SHALL be two's-complemented over 2*WIDTH bits.
REQ-027 Recombination SHALL be Z = la_lb + ((la_hb+ha_lb) << WIDTH/2) + (ha_hb << WIDTH), with the mid-sum carry retained (WIDTH+1 bits).
REQ-028 Z SHALL be bit-exact with the mathematical product for all operands and modes.
REQ-029 mode and tag SHALL travel with their beat; beats SHALL never reorder.
REQ-030 flush=1 SHALL clear all stage valid bits at the next edge; a beat presented in the flush cycle SHALL NOT be accepted; out_valid SHALL be 0 the cycle after flush.
REQ-031 flush SHALL override simultaneous accept and output handshake; an output handshake in the flush cycle still completes for the consumer.
REQ-032 busy SHALL be the OR of s1/s2/s3 valid bits.

Reset
REQ-033 While rst_n=0: all valid bits 0, out_valid=0, busy=0, Z=0, out_tag=0, data registers 0, asynchronously.
REQ-034 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after deassertion.
REQ-035 Reset mid-operation SHALL drop all in-flight beats with no output produced for them.

Verification (WIDTH=8, TAG_WIDTH=4)
REQ-036 UU A=0xFF B=0xFF tag=3, out_ready=1 -> 3 cycles later out_valid=1, Z=0xFE01, out_tag=3.
REQ-037 SS A=0x80 B=0x80 -> Z=0x4000; SS A=0x80 B=0x7F -> Z=0xC080; SU A=0xFF B=0xFF -> Z=0xFF01; mode 11 A=0xFF B=0x02 -> Z=0x01FE.
REQ-038 Back-to-back 10 beats, out_ready=1 -> 10 consecutive out_valid cycles, in order, each Z correct.
REQ-039 out_ready=0 with 4 beats offered -> 3 accepted, in_ready=0 on 4th, Z held stable; out_ready=1 -> drain in order, 4th then accepted.
REQ-040 flush with 2 beats in flight and in_valid=1 -> next cycle busy=0, out_valid=0, offered beat not accepted, no stale output later.
REQ-041 rst_n low for 1 cycle with 3 beats in flight -> outputs 0 immediately, no result emitted for those beats, in_ready=1 after release.

Source files
------------

// File: rtl/vedic_mul_pipe.sv
// -----------------------------------------------------------------------------
// vedic_mul_pipe: 3-stage pipelined WIDTH x WIDTH multiplier with UU/SS/SU
// modes, built around a recursive unsigned vedic (urdhva) core.
//   S1: operand magnitudes + result sign
//   S2: four WIDTH/2 x WIDTH/2 partial products
//   S3: recombined, sign-corrected 2*WIDTH product
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             synchronous kill of every in-flight beat
//   in_valid/in_ready operand handshake (in_ready is combinational)
//   A, B, mode        operands; mode 00 UU, 01 SS, 10 SU, 11 UU
//   in_tag            sideband carried alongside the beat
//   out_valid/out_ready result handshake
//   Z, out_tag        full product and its tag
//   busy              any stage holds a valid beat
// -----------------------------------------------------------------------------

// Recursive unsigned vedic multiplier; splits in half until W <= 2**MIN_LVL.
module vedic_umul #(
    parameter int unsigned W       = 8,
    parameter int unsigned MIN_LVL = 2
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_z_c
);
    localparam int unsigned LEAF_W = 32'd1 << MIN_LVL;

    if (W <= LEAF_W || W < 2) begin : g_leaf
        assign o_z_c = (2*W)'(i_a) * (2*W)'(i_b);
    end else begin : g_split
        localparam int unsigned H = W / 2;

        logic [W-1:0] w_ll;
        logic [W-1:0] w_lh;
        logic [W-1:0] w_hl;
        logic [W-1:0] w_hh;
        logic [W:0]   w_mid;

        vedic_umul #(.W(H), .MIN_LVL(MIN_LVL)) u_ll (
            .i_a(i_a[H-1:0]), .i_b(i_b[H-1:0]), .o_z_c(w_ll));
        vedic_umul #(.W(H), .MIN_LVL(MIN_LVL)) u_lh (
            .i_a(i_a[H-1:0]), .i_b(i_b[W-1:H]), .o_z_c(w_lh));
        vedic_umul #(.W(H), .MIN_LVL(MIN_LVL)) u_hl (
            .i_a(i_a[W-1:H]), .i_b(i_b[H-1:0]), .o_z_c(w_hl));
        vedic_umul #(.W(H), .MIN_LVL(MIN_LVL)) u_hh (
            .i_a(i_a[W-1:H]), .i_b(i_b[W-1:H]), .o_z_c(w_hh));

        // Cross terms keep their carry; ll and hh never overlap so they concatenate.
        assign w_mid = (W+1)'(w_lh) + (W+1)'(w_hl);
        assign o_z_c = {w_hh, w_ll} + ((2*W)'(w_mid) << H);
    end
endmodule

module vedic_mul_pipe #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned MIN_MUL_LEVEL = 4,
    parameter int unsigned TAG_WIDTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    input  logic [1:0]             mode,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     Z,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic                   busy
);
    localparam int unsigned HALF = WIDTH / 2;
    localparam logic [1:0]  MODE_SS = 2'b01;
    localparam logic [1:0]  MODE_SU = 2'b10;

    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $fatal(1, "vedic_mul_pipe: WIDTH must be a power of 2 and >= 4");
    end

    // Stage registers
    logic                   r_s1_valid;
    logic [WIDTH-1:0]       r_s1_mag_a;
    logic [WIDTH-1:0]       r_s1_mag_b;
    logic                   r_s1_neg;
    logic [TAG_WIDTH-1:0]   r_s1_tag;

    logic                   r_s2_valid;
    logic [WIDTH-1:0]       r_pp_ll;
    logic [WIDTH-1:0]       r_pp_lh;
    logic [WIDTH-1:0]       r_pp_hl;
    logic [WIDTH-1:0]       r_pp_hh;
    logic                   r_s2_neg;
    logic [TAG_WIDTH-1:0]   r_s2_tag;

    logic                   r_s3_valid;
    logic [2*WIDTH-1:0]     r_z;
    logic [TAG_WIDTH-1:0]   r_s3_tag;

    // Combinational nets
    logic                   w_s1_en;
    logic                   w_s2_en;
    logic                   w_s3_en;
    logic                   w_accept;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic [WIDTH-1:0]       w_pp_ll;
    logic [WIDTH-1:0]       w_pp_lh;
    logic [WIDTH-1:0]       w_pp_hl;
    logic [WIDTH-1:0]       w_pp_hh;
    logic [WIDTH:0]         w_mid;
    logic [2*WIDTH-1:0]     w_mag_prod;
    logic [2*WIDTH-1:0]     w_prod;

    // Stage enables: a stage loads when empty or when its successor loads.
    assign w_s3_en  = !r_s3_valid | out_ready;
    assign w_s2_en  = !r_s2_valid | w_s3_en;
    assign w_s1_en  = !r_s1_valid | w_s2_en;
    assign in_ready = rst_n & w_s1_en & !flush;
    assign w_accept = in_valid & in_ready;

    // Operand magnitudes; negating the most negative value wraps to 2^(WIDTH-1),
    // which is exactly the correct unsigned magnitude.
    assign w_a_neg = ((mode == MODE_SS) || (mode == MODE_SU)) & A[WIDTH-1];
    assign w_b_neg = (mode == MODE_SS) & B[WIDTH-1];
    assign w_mag_a = w_a_neg ? -A : A;
    assign w_mag_b = w_b_neg ? -B : B;

    // Partial products of the S1 magnitudes
    vedic_umul #(.W(HALF), .MIN_LVL(MIN_MUL_LEVEL)) u_pp_ll (
        .i_a(r_s1_mag_a[HALF-1:0]),     .i_b(r_s1_mag_b[HALF-1:0]),     .o_z_c(w_pp_ll));
    vedic_umul #(.W(HALF), .MIN_LVL(MIN_MUL_LEVEL)) u_pp_lh (
        .i_a(r_s1_mag_a[HALF-1:0]),     .i_b(r_s1_mag_b[WIDTH-1:HALF]), .o_z_c(w_pp_lh));
    vedic_umul #(.W(HALF), .MIN_LVL(MIN_MUL_LEVEL)) u_pp_hl (
        .i_a(r_s1_mag_a[WIDTH-1:HALF]), .i_b(r_s1_mag_b[HALF-1:0]),     .o_z_c(w_pp_hl));
    vedic_umul #(.W(HALF), .MIN_LVL(MIN_MUL_LEVEL)) u_pp_hh (
        .i_a(r_s1_mag_a[WIDTH-1:HALF]), .i_b(r_s1_mag_b[WIDTH-1:HALF]), .o_z_c(w_pp_hh));

    // Recombination with retained mid-sum carry, then sign correction
    assign w_mid      = (WIDTH+1)'(r_pp_lh) + (WIDTH+1)'(r_pp_hl);
    assign w_mag_prod = {r_pp_hh, r_pp_ll} + ((2*WIDTH)'(w_mid) << HALF);
    assign w_prod     = r_s2_neg ? -w_mag_prod : w_mag_prod;

    // Valid bits; flush wins over every handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else begin
            if (w_s1_en) r_s1_valid <= w_accept;
            if (w_s2_en) r_s2_valid <= r_s1_valid;
            if (w_s3_en) r_s3_valid <= r_s2_valid;
        end
    end

    // Datapath registers load only when a real beat moves in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_mag_a <= '0;
            r_s1_mag_b <= '0;
            r_s1_neg   <= 1'b0;
            r_s1_tag   <= '0;
            r_pp_ll    <= '0;
            r_pp_lh    <= '0;
            r_pp_hl    <= '0;
            r_pp_hh    <= '0;
            r_s2_neg   <= 1'b0;
            r_s2_tag   <= '0;
            r_z        <= '0;
            r_s3_tag   <= '0;
        end else begin
            if (w_accept) begin
                r_s1_mag_a <= w_mag_a;
                r_s1_mag_b <= w_mag_b;
                r_s1_neg   <= w_a_neg ^ w_b_neg;
                r_s1_tag   <= in_tag;
            end
            if (w_s2_en && r_s1_valid) begin
                r_pp_ll  <= w_pp_ll;
                r_pp_lh  <= w_pp_lh;
                r_pp_hl  <= w_pp_hl;
                r_pp_hh  <= w_pp_hh;
                r_s2_neg <= r_s1_neg;
                r_s2_tag <= r_s1_tag;
            end
            if (w_s3_en && r_s2_valid) begin
                r_z      <= w_prod;
                r_s3_tag <= r_s2_tag;
            end
        end
    end

    assign out_valid = r_s3_valid;
    assign Z         = r_z;
    assign out_tag   = r_s3_tag;
    assign busy      = r_s1_valid | r_s2_valid | r_s3_valid;
endmodule

// File: tb/tb_vedic_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_vedic_mul_pipe: directed self-checking bench for vedic_mul_pipe (WIDTH=8).
// A negedge monitor scores every output handshake against an in-order queue of
// expected results pushed on every accepted beat.
// -----------------------------------------------------------------------------
module tb_vedic_mul_pipe;
    localparam int unsigned W  = 8;
    localparam int unsigned TW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      A = '0;
    logic [W-1:0]      B = '0;
    logic [1:0]        mode = 2'b00;
    logic [TW-1:0]     in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [2*W-1:0]    Z;
    logic [TW-1:0]     out_tag;
    logic              busy;

    logic [2*W-1:0]    cur_exp = '0;

    typedef struct {
        logic [2*W-1:0] z;
        logic [TW-1:0]  tag;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    vedic_mul_pipe #(.WIDTH(W), .MIN_MUL_LEVEL(1), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .mode(mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .Z(Z), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference product from plain signed/unsigned integer arithmetic
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] m);
        longint sa;
        longint sb;
        longint p;
        sa = (m == 2'b01 || m == 2'b10) ? longint'($signed(a)) : longint'({56'd0, a});
        sb = (m == 2'b01)               ? longint'($signed(b)) : longint'({56'd0, b});
        p  = sa * sb;
        return p[2*W-1:0];
    endfunction

    // Scoreboard: check output beats in order, record accepted beats
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", out_valid, 0);
                end else begin
                    check_eq("z", Z, exp_q[0].z);
                    check_eq("out_tag", out_tag, exp_q[0].tag);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back('{cur_exp, in_tag});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; returns just after the accept edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                        input logic [TW-1:0] t, input logic [2*W-1:0] e);
        bit done = 1'b0;
        A = a; B = b; mode = m; in_tag = t; cur_exp = e; in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        check_eq("send_accept", done, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tg);
        bit idle = 1'b0;
        for (int i = 0; i < 50 && !idle; i++) begin
            @(negedge clk);
            idle = !busy && (exp_q.size() == 0);
        end
        check_eq(tg, idle, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_z", Z, 0);
        check_eq("rst_out_tag", out_tag, 0);
        check_eq("rst_in_ready", in_ready, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("in_ready_after_rst", in_ready, 1);
        tick();

        // UU 0xFF*0xFF with exact 3-cycle latency
        send(8'hFF, 8'hFF, 2'b00, 4'd3, 16'hFE01);
        @(negedge clk); check_eq("lat_c1_ov", out_valid, 0);
        @(negedge clk); check_eq("lat_c2_ov", out_valid, 0);
        @(negedge clk); check_eq("lat_c3_ov", out_valid, 1);
        check_eq("lat_z", Z, 16'hFE01);
        check_eq("lat_tag", out_tag, 3);
        tick();
        drain("drain_latency");

        // Sign modes and boundary operands
        send(8'h80, 8'h80, 2'b01, 4'd1, 16'h4000);
        send(8'h80, 8'h7F, 2'b01, 4'd2, 16'hC080);
        send(8'hFF, 8'hFF, 2'b10, 4'd4, 16'hFF01);
        send(8'hFF, 8'h02, 2'b11, 4'd5, 16'h01FE);
        drain("drain_modes");

        // Ten back-to-back beats, full throughput
        for (int i = 0; i < 10; i++) begin
            A = 8'(i * 37 + 5);
            B = 8'(240 - i * 19);
            mode = 2'(i);
            in_tag = 4'(i);
            cur_exp = model(A, B, mode);
            in_valid = 1'b1;
            @(negedge clk);
            check_eq("b2b_in_ready", in_ready, 1);
            check_eq("b2b_out_valid", out_valid, i >= 3);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("b2b_tail_ov", out_valid, i < 3);
        end
        tick();
        drain("drain_b2b");

        // Backpressure: three beats fill the pipe, the fourth waits
        out_ready = 1'b0;
        send(8'h12, 8'h34, 2'b00, 4'd1, 16'h03A8);
        send(8'h80, 8'h01, 2'b01, 4'd2, 16'hFF80);
        send(8'h7F, 8'h80, 2'b10, 4'd4, 16'h3F80);
        A = 8'hFE; B = 8'hFE; mode = 2'b01; in_tag = 4'd5; cur_exp = 16'h0004; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_out_valid", out_valid, 1);
            check_eq("bp_busy", busy, 1);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        drain("drain_bp");

        // Flush with two beats in flight and a beat offered
        send(8'h0F, 8'h0F, 2'b00, 4'd6, 16'h00E1);
        send(8'h33, 8'h03, 2'b00, 4'd7, 16'h0099);
        A = 8'h55; B = 8'h02; mode = 2'b00; in_tag = 4'd8; cur_exp = 16'h00AA;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        check_eq("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_busy", busy, 0);
        check_eq("flush_out_valid", out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("flush_no_stale", out_valid, 0);
        end
        tick();
        drain("drain_flush");

        // Reset with three beats in flight
        send(8'h02, 8'h03, 2'b00, 4'd9,  16'h0006);
        send(8'hFF, 8'h01, 2'b01, 4'd10, 16'hFFFF);
        send(8'h10, 8'h10, 2'b00, 4'd11, 16'h0100);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("mrst_out_valid", out_valid, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_z", Z, 0);
        check_eq("mrst_out_tag", out_tag, 0);
        check_eq("mrst_in_ready", in_ready, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mrst_in_ready_after", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("mrst_no_output", out_valid, 0);
        end
        tick();
        send(8'h0C, 8'h0B, 2'b00, 4'd12, 16'h0084);
        drain("drain_after_mrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
